// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: PC, DEPTH-entry prefetch queue and IF/ID latch.
// Requests are throttled so that every issued fetch always has a free queue slot.
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PCSrc,
  input  logic [XLEN-1:0]          branch_target,
  input  logic                     stall,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     imem_valid,
  output logic [XLEN-1:0]          IR_out,
  output logic [XLEN-1:0]          PC4_out,
  output logic                     id_valid,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, addr_pipe_q, ir_q, pc4_q;
  logic [XLEN-1:0] qi_q [DEPTH];
  logic [XLEN-1:0] qp_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d, fill;
  logic            inflight_q, drop_next_q, id_valid_q, overflow_q;
  logic            req, discard, pop, full, push_att, push, ovf;

  always_comb begin
    fill     = count_q + CW'(inflight_q);
    // Gated by rst_n so no fetch is requested while reset is held.
    req      = rst_n && !PCSrc && (fill < CW'(DEPTH));
    discard  = PCSrc || drop_next_q;
    pop      = !PCSrc && !stall && (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    push_att = imem_valid && !discard;
    push     = push_att && (!full || pop);
    ovf      = push_att && full && !pop;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      addr_pipe_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      drop_next_q <= 1'b0;
      ir_q        <= '0;
      pc4_q       <= '0;
      id_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_q | ovf;
      if (PCSrc) begin
        pc_q        <= branch_target;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        inflight_q  <= 1'b0;
        drop_next_q <= inflight_q;
        ir_q        <= '0;
        pc4_q       <= '0;
        id_valid_q  <= 1'b0;
      end else begin
        if (req) begin
          pc_q        <= pc_q + XLEN'(4);
          addr_pipe_q <= pc_q;
        end
        inflight_q  <= req;
        drop_next_q <= 1'b0;
        count_q     <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (!stall) begin
          if (pop) begin
            ir_q       <= qi_q[rd_ptr_q];
            pc4_q      <= qp_q[rd_ptr_q];
            id_valid_q <= 1'b1;
          end else begin
            ir_q       <= '0;
            pc4_q      <= '0;
            id_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  // Queue storage needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      qi_q[wr_ptr_q] <= imem_rdata;
      qp_q[wr_ptr_q] <= addr_pipe_q + XLEN'(4);
    end
  end

  assign imem_req     = req;
  assign imem_addr    = pc_q;
  assign IR_out       = ir_q;
  assign PC4_out      = pc4_q;
  assign id_valid     = id_valid_q;
  assign q_count      = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue between instruction memory and the IF/ID latch.
- Replaces the single-register IF stage. Adds decoupled prefetch, ID-stage stall, and branch redirect with a full flush via PCSrc.
- Sits between the PC/instruction memory and the decode stage. Feeds IR_out and PC+4 into the ID stage.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 4, prefetch queue entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PCSrc  in  1  branch/jump taken; redirect and flush.
- branch_target  in  XLEN  redirect PC, sampled when PCSrc=1.
- stall  in  1  ID-stage hazard stall; hold the IF/ID latch.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address (equals the PC register).
- imem_rdata  in  XLEN  instruction, valid the cycle after the request.
- imem_valid  in  1  qualifies imem_rdata.
- IR_out  out  XLEN  IF/ID instruction latch.
- PC4_out  out  XLEN  IF/ID latched address+4 of IR_out.
- id_valid  out  1  IF/ID latch holds a real instruction.
- q_count  out  clog2(DEPTH)+1  current queue occupancy.
- overflow_err  out  1  sticky; response arrived while the queue was full.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; queue empty; q_count=0; no in-flight request.
  - IR_out=0 (nop); PC4_out=0; id_valid=0; overflow_err=0.
  - imem_req=0 while in reset.
  - A reset asserted mid-operation discards all queued and in-flight data immediately.
- Request rule (combinational):
  - imem_req = !PCSrc && (q_count + inflight < DEPTH).
  - inflight is a 1-bit register: set at the edge where imem_req=1, cleared otherwise.
  - imem_addr = PC. On each request edge, PC <= PC + 4, wrapping modulo 2^XLEN.
  - Each queue entry stores {instr, addr+4}. addr+4 is captured from an internal address pipe register holding the issued address.
- Response rule:
  - At an edge with imem_valid=1 and no discard, push {imem_rdata, issued_addr+4}.
  - Discard condition: PCSrc=1 in the response cycle, or a redirect occurred in the request cycle. This is tracked by a drop_next flag.
  - A push while the queue is full (not popped this edge) is dropped and sets overflow_err. The flag clears only on reset. With the request rule this is unreachable; the verifier checks it stays 0.
- Pop / IF/ID latch, evaluated at each edge in priority order:
  1. PCSrc=1: IR_out<=0, PC4_out<=0, id_valid<=0. Queue emptied (count=0, pointers reset). PC<=branch_target. drop_next<=inflight.
  2. stall=1: latch holds all values, no pop. Pushes still occur.
  3. Queue non-empty: pop the head into IR_out/PC4_out, id_valid<=1.
  4. Queue empty: bubble, IR_out<=0, PC4_out<=0, id_valid<=0.
- There is no bypass from imem_rdata to the latch.
- Latency: request in cycle n, push at end of n+1, IR_out valid after end of n+2. This gives 3 edges from the request edge to IR_out.
- Simultaneous push and pop:
  - Count is unchanged; legal at full and at empty+1.
  - Pop at empty uses only previously stored entries.
- Pointers: rd/wr pointers are clog2(DEPTH) bits and wrap naturally. Count is tracked separately, so full and empty are unambiguous.
- Stall concurrent with PCSrc: flush wins.
- Throughput:
  - Steady state, no stall: one instruction per cycle.
  - Under a sustained stall: the queue fills to DEPTH, then imem_req deasserts.

Test Plan:
- Reset then run: RESET_PC=0, imem returns 0x1000_0000+addr each cycle, no stall. Required:
  - imem_addr = 0, 4, 8, …
  - First id_valid=1 on the 3rd edge after reset release, with IR_out=0x1000_0000 and PC4_out=4.
  - Then one instruction per cycle in order.
- Stall fill: assert stall for 8 cycles mid-stream (DEPTH=4).
  - Required: q_count rises to 4, imem_req drops to 0, IR_out and PC4_out unchanged.
  - On release: consecutive addresses resume with no skip or duplicate.
- Branch redirect: PCSrc=1 with branch_target=0x40 while the queue holds 3 entries and one request is in flight.
  - Required next edge: id_valid=0, IR_out=0, q_count=0, in-flight response dropped.
  - imem_addr=0x40 the following cycle; first delivered PC4_out=0x44.
- PCSrc together with stall=1: flush still occurs (id_valid=0, q_count=0).
- Wrap-around: PC starts at 0xFFFF_FFF8. Required: addresses FFF8, FFFC, 0000, 0004; PC4_out for FFFC is 0x0000_0000.
- Async reset mid-stream with the queue at 2: rst_n low between edges. Required immediately: id_valid=0, q_count=0, imem_req=0. After release, fetch restarts at RESET_PC; overflow_err=0 throughout.
